// File: rtl/ksa_result_reader.sv
`timescale 1ns/1ps
// Post-decryption checker for the RC4 key search: scans RAM A for lowercase/space bytes
// and, on success, shows the candidate key on six seven-segment digits.
module ksa_result_reader #(
  parameter int MESSAGE_LENGTH     = 32,
  parameter int MESSAGE_LOG_LENGTH = 5,
  parameter int RAM_WIDTH          = 8,
  parameter int RAM_LENGTH         = 8,
  parameter int KEY_WIDTH          = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [KEY_WIDTH-1:0]          key_in,
  output logic [RAM_LENGTH-1:0]         aAddr,
  input  logic [RAM_WIDTH-1:0]          aOut,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [MESSAGE_LOG_LENGTH-1:0] fail_index,
  output logic [KEY_WIDTH-1:0]          key_out,
  output logic [6:0]                    HEX0,
  output logic [6:0]                    HEX1,
  output logic [6:0]                    HEX2,
  output logic [6:0]                    HEX3,
  output logic [6:0]                    HEX4,
  output logic [6:0]                    HEX5,
  output logic [2:0]                    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                        state;
  logic [MESSAGE_LOG_LENGTH-1:0] index;
  logic                          byte_ok;
  logic                          last_byte;
  logic                          show_key;

  assign state_dbg = state;

  assign byte_ok = ((aOut >= RAM_WIDTH'(8'h61)) && (aOut <= RAM_WIDTH'(8'h7A))) ||
                   (aOut == RAM_WIDTH'(8'h20));
  assign last_byte = (index == MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1));
  assign show_key  = done && pass;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // start is a one-cycle request, accepted only in IDLE or DONE; while busy it is dropped.
  // A start held high in DONE re-triggers the scan every time DONE is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      index      <= '0;
      aAddr      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_index <= '0;
      key_out    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            key_out <= key_in;
            index   <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
            busy    <= 1'b1;
            state   <= S_READ;
          end
        end
        S_READ: begin
          aAddr <= RAM_LENGTH'(index);
          state <= S_WAIT;
        end
        // RAM A registers the address, so data appears one cycle after it is sampled.
        S_WAIT: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (!byte_ok) begin
            fail_index <= index;
            pass       <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_DONE;
          end else if (last_byte) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            index <= index + 1'b1;
            state <= S_READ;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Display follows the registered done/pass, hence one cycle behind them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HEX0 <= 7'h7F;
      HEX1 <= 7'h7F;
      HEX2 <= 7'h7F;
      HEX3 <= 7'h7F;
      HEX4 <= 7'h7F;
      HEX5 <= 7'h7F;
    end else begin
      HEX0 <= show_key ? hex_glyph(key_out[3:0])   : 7'h7F;
      HEX1 <= show_key ? hex_glyph(key_out[7:4])   : 7'h7F;
      HEX2 <= show_key ? hex_glyph(key_out[11:8])  : 7'h7F;
      HEX3 <= show_key ? hex_glyph(key_out[15:12]) : 7'h7F;
      HEX4 <= show_key ? hex_glyph(key_out[19:16]) : 7'h7F;
      HEX5 <= show_key ? hex_glyph(key_out[23:20]) : 7'h7F;
    end
  end

endmodule

// File: tb/tb_ksa_result_reader.sv
`timescale 1ns/1ps
// Bench for ksa_result_reader: registered-read RAM model, scan scenarios and a result scoreboard.
module tb_ksa_result_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] key_in = '0;
  logic [7:0]  aAddr;
  logic [7:0]  aOut = '0;
  logic        busy, done, pass;
  logic [4:0]  fail_index;
  logic [23:0] key_out;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [2:0]  state_dbg;

  logic [7:0]  mem [256];
  int          n_cmp = 0;
  int          n_err = 0;
  // {pass, fail_index, key, cycles to done}
  logic [45:0] exp_q [$];
  logic [6:0]  glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  ksa_result_reader dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in),
    .aAddr(aAddr), .aOut(aOut), .busy(busy), .done(done), .pass(pass),
    .fail_index(fail_index), .key_out(key_out),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) aOut <= mem[aAddr];

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic fill_random_valid();
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = (($urandom_range(0, 7)) == 0) ? 8'h20 : 8'(8'h61 + $urandom_range(0, 25));
      mem[i] = v;
    end
  endtask

  function automatic logic [45:0] model(input logic [23:0] key);
    int         k = 32;
    logic       p = 1'b1;
    logic [4:0] fi = '0;
    logic       ok;
    for (int i = 0; i < 32; i++) begin
      ok = (mem[i] == 8'h20) || (mem[i] >= 8'h61 && mem[i] <= 8'h7A);
      if (p && !ok) begin
        p  = 1'b0;
        fi = i[4:0];
        k  = i + 1;
      end
    end
    return {p, fi, key, 16'(3 * k)};
  endfunction

  // Pulses start, optionally injects a second start at a given cycle, then checks the result.
  task automatic run_scan(input logic [23:0] key, input int inject_at, input logic [23:0] key2,
                          output int busy_cnt);
    int          cycles;
    logic [45:0] e;
    logic [6:0]  hx [6];
    logic [6:0]  want;
    busy_cnt = 0;
    cycles = 0;
    @(negedge clk);
    start = 1'b1;
    key_in = key;
    exp_q.push_back(model(key));
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL scan_done_cleared: got %0b want 0", done); end
    n_cmp++; if (key_out !== key) begin n_err++; $display("FAIL scan_key_latched: got %h want %h", key_out, key); end
    while (!done && cycles < 200) begin
      if (busy) busy_cnt++;
      if (cycles == 1) begin
        hx = '{HEX0, HEX1, HEX2, HEX3, HEX4, HEX5};
        for (int d = 0; d < 6; d++) begin
          n_cmp++; if (hx[d] !== 7'h7F) begin n_err++; $display("FAIL scan_hex_blank HEX%0d: got %h want 7f", d, hx[d]); end
        end
      end
      if (cycles == inject_at) begin
        start = 1'b1;
        key_in = key2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL scan_timeout: done not seen after %0d cycles", cycles);
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    n_cmp++; if (cycles !== int'(e[15:0])) begin n_err++; $display("FAIL scan_latency: got %0d want %0d", cycles, e[15:0]); end
    n_cmp++; if (pass !== e[45]) begin n_err++; $display("FAIL scan_pass: got %0b want %0b", pass, e[45]); end
    if (!e[45]) begin
      n_cmp++; if (fail_index !== e[44:40]) begin n_err++; $display("FAIL scan_fail_index: got %0d want %0d", fail_index, e[44:40]); end
    end
    n_cmp++; if (key_out !== e[39:16]) begin n_err++; $display("FAIL scan_key_out: got %h want %h", key_out, e[39:16]); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL scan_busy_at_done: got %0b want 0", busy); end
    @(posedge clk);
    #1;
    hx = '{HEX0, HEX1, HEX2, HEX3, HEX4, HEX5};
    for (int d = 0; d < 6; d++) begin
      want = e[45] ? glyph_tab[e[16 + 4*d +: 4]] : 7'h7F;
      n_cmp++; if (hx[d] !== want) begin n_err++; $display("FAIL scan_hex HEX%0d: got %h want %h", d, hx[d], want); end
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL scan_done_held: got %0b want 1", done); end
  endtask

  task automatic test_reset();
    logic [6:0] hx [6];
    reset = 1'b1;
    start = 1'b1;
    key_in = 24'h123456;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", done); end
    n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL reset_pass: got %0b want 0", pass); end
    n_cmp++; if (fail_index !== 5'd0) begin n_err++; $display("FAIL reset_fail_index: got %0d want 0", fail_index); end
    n_cmp++; if (key_out !== 24'h0) begin n_err++; $display("FAIL reset_key_out: got %h want 0", key_out); end
    n_cmp++; if (aAddr !== 8'h0) begin n_err++; $display("FAIL reset_aAddr: got %h want 0", aAddr); end
    n_cmp++; if (state_dbg !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    hx = '{HEX0, HEX1, HEX2, HEX3, HEX4, HEX5};
    for (int d = 0; d < 6; d++) begin
      n_cmp++; if (hx[d] !== 7'h7F) begin n_err++; $display("FAIL reset_hex HEX%0d: got %h want 7f", d, hx[d]); end
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_after_release: got %0b want 0", busy); end
  endtask

  task automatic test_all_pass();
    int bc;
    fill(8'h61);
    run_scan(24'h0A1B2C, -1, 24'h0, bc);
    n_cmp++; if (bc !== 96) begin n_err++; $display("FAIL all_pass_busy_cycles: got %0d want 96", bc); end
  endtask

  task automatic test_boundary_mix();
    int bc;
    fill(8'h62);
    mem[0] = 8'h20; mem[1] = 8'h7A; mem[2] = 8'h61; mem[5] = 8'h7B;
    run_scan(24'h5A5A5A, -1, 24'h0, bc);
  endtask

  task automatic test_first_and_last();
    int bc;
    fill(8'h61);
    mem[0] = 8'h60;
    run_scan(24'h000001, -1, 24'h0, bc);
    fill_random_valid();
    mem[31] = 8'hFF;
    run_scan(24'h00ABCD, -1, 24'h0, bc);
    fill(8'h7A);
    mem[12] = 8'h00;
    run_scan(24'h777777, -1, 24'h0, bc);
  endtask

  task automatic test_start_while_busy();
    int bc;
    fill_random_valid();
    run_scan(24'h123456, 10, 24'hABCDEF, bc);
    n_cmp++; if (bc !== 96) begin n_err++; $display("FAIL ignore_busy_cycles: got %0d want 96", bc); end
  endtask

  task automatic test_reset_mid_scan();
    int         bc;
    logic [6:0] hx [6];
    fill(8'h61);
    @(negedge clk);
    start = 1'b1;
    key_in = 24'h3C3C3C;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %0b want 0", done); end
    n_cmp++; if (aAddr !== 8'h0) begin n_err++; $display("FAIL midreset_aAddr: got %h want 0", aAddr); end
    hx = '{HEX0, HEX1, HEX2, HEX3, HEX4, HEX5};
    for (int d = 0; d < 6; d++) begin
      n_cmp++; if (hx[d] !== 7'h7F) begin n_err++; $display("FAIL midreset_hex HEX%0d: got %h want 7f", d, hx[d]); end
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (aAddr !== 8'h0) begin n_err++; $display("FAIL midreset_no_reads: got %h want 0", aAddr); end
    fill_random_valid();
    run_scan(24'hC0FFEE, -1, 24'h0, bc);
  endtask

  task automatic test_rescan_from_done();
    int bc;
    fill(8'h20);
    run_scan(24'h9876D4, -1, 24'h0, bc);
    fill(8'h61);
    mem[7] = 8'h41;
    run_scan(24'hFFFFFF, -1, 24'h0, bc);
  endtask

  initial begin
    fill(8'h00);
    test_reset();
    test_all_pass();
    test_boundary_mix();
    test_first_and_last();
    test_start_while_busy();
    test_reset_mid_scan();
    test_rescan_from_done();
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
